// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, loader FSM states and ALU opcodes
// for the operand loader and the ALU operation units.
package alu_pkg;

  localparam int DATA_W = 6;
  localparam int OP_W   = 2;

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    PRESENT = 2'b11
  } ld_state_t;

  localparam logic [OP_W-1:0] OP_AND = 2'd0;
  localparam logic [OP_W-1:0] OP_OR  = 2'd1;
  localparam logic [OP_W-1:0] OP_XOR = 2'd2;
  localparam logic [OP_W-1:0] OP_ADD = 2'd3;

endpackage

// File: rtl/alu_operand_loader_button.sv
// button_conditioner: 2-flop sync, optional debounce, rising-edge pulse.
// Debounce filter enabled by ALU_LOADER_DEBOUNCE_EN.
module button_conditioner #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [1:0] sync;
  logic       level;
  logic       level_q;

  if (DB_CYCLES < 1) begin : g_bad_db
    $error("DB_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], btn};
  end

`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt;

  // level follows sync only after DB_CYCLES straight cycles of disagreement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      cnt   <= '0;
      level <= sync[1];
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign level = sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: captures A, B and opcode from one switch bank
// and offers them downstream (debounce via ALU_LOADER_DEBOUNCE_EN).
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int DATA_W    = alu_pkg::DATA_W,
  parameter int OP_W      = alu_pkg::OP_W,
  parameter int DB_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_load,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   op,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [1:0]        state_o
);

  ld_state_t state;
  logic      load_p;
  logic      clr_p;

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_load (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_load),
    .pulse (load_p)
  );

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clear),
    .pulse (clr_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A        <= '0;
      B        <= '0;
      op       <= '0;
      op_valid <= 1'b0;
      state    <= LOAD_A;
    end else if (clr_p) begin
      A        <= '0;
      B        <= '0;
      op       <= '0;
      op_valid <= 1'b0;
      state    <= LOAD_A;
    end else begin
      unique case (state)
        LOAD_A: if (load_p) begin
          A     <= sw;
          state <= LOAD_B;
        end
        LOAD_B: if (load_p) begin
          B     <= sw;
          state <= LOAD_OP;
        end
        LOAD_OP: if (load_p) begin
          op       <= sw[OP_W-1:0];
          op_valid <= 1'b1;
          state    <= PRESENT;
        end
        PRESENT: if (op_ready) begin
          op_valid <= 1'b0;
          state    <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed + random checks of the operand loader
// against a sequence-level model of the load/present/clear rules.
module tb_alu_operand_loader;

  localparam int DB = 4;
`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] sw = '0;
  logic       btn_load = 1'b0;
  logic       btn_clear = 1'b0;
  logic       op_ready = 1'b0;
  logic [5:0] A, B;
  logic [1:0] op;
  logic       op_valid;
  logic [1:0] state_o;

  int n_chk = 0;
  int n_fail = 0;

  // model: how many of the three words have been loaded (3 = presenting)
  int         m_cnt = 0;
  logic [5:0] m_a = '0, m_b = '0;
  logic [1:0] m_op = '0;

  alu_operand_loader #(.DATA_W(6), .OP_W(2), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_load  (btn_load),
    .btn_clear (btn_clear),
    .A         (A),
    .B         (B),
    .op        (op),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".A"}, 32'(A), 32'(m_a));
    chk({tag, ".B"}, 32'(B), 32'(m_b));
    chk({tag, ".op"}, 32'(op), 32'(m_op));
    chk({tag, ".valid"}, 32'(op_valid), 32'(m_cnt == 3));
    chk({tag, ".state"}, 32'(state_o), 32'(m_cnt));
  endtask

  function automatic void m_load(input logic [5:0] v);
    if      (m_cnt == 0) m_a = v;
    else if (m_cnt == 1) m_b = v;
    else if (m_cnt == 2) m_op = v[1:0];
    if (m_cnt < 3) m_cnt++;
  endfunction

  function automatic void m_clear();
    m_a = '0; m_b = '0; m_op = '0; m_cnt = 0;
  endfunction

  task automatic press_load(input logic [5:0] v);
    sw = v;
    btn_load = 1'b1;
    tick(LAT + 2);
    btn_load = 1'b0;
    tick(LAT + 2);
    m_load(v);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    tick(LAT + 2);
    btn_clear = 1'b0;
    tick(LAT + 2);
    m_clear();
  endtask

  task automatic ready_pulse();
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    tick(1);
    if (m_cnt == 3) m_cnt = 0;
  endtask

  // raise btn_load now; return edges until state_o moves (0 = timeout)
  task automatic measure(output int lat);
    logic [1:0] s0;
    s0 = state_o;
    lat = 0;
    btn_load = 1'b1;
    for (int i = 1; i <= LAT + 20; i++) begin
      tick(1);
      if (state_o != s0) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ones;
    tick(2);
    check_all("reset");
    rst_n = 1'b1;
    tick(2);
    check_all("post_reset");

    // first press with latency measurement
    sw = 6'h2A;
    measure(lat);
    chk("latency_clean", 32'(lat), 32'(LAT));
    tick(LAT + 2);
    btn_load = 1'b0;
    tick(LAT + 2);
    m_load(6'h2A);
    check_all("load_a");
    press_load(6'h15);
    check_all("load_b");
    press_load(6'h03);
    check_all("load_op");

    // handshake completes; values stay
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    m_cnt = 0;
    check_all("handshake");

`ifdef ALU_LOADER_DEBOUNCE_EN
    // bouncing press: only the final stable rise counts
    sw = 6'h2C;
    btn_load = 1'b1; tick(2);
    btn_load = 1'b0; tick(2);
    btn_load = 1'b1; tick(2);
    btn_load = 1'b0; tick(4);
    chk("bounce_no_capture", 32'(state_o), 32'(0));
    measure(lat);
    chk("latency_bounce", 32'(lat), 32'(2 + DB + 1));
    tick(LAT + 2);
    btn_load = 1'b0;
    tick(LAT + 2);
    m_load(6'h2C);
    check_all("bounce");
    press_clear();
`endif

    // held button: one capture only
    sw = 6'h27;
    btn_load = 1'b1;
    tick(100);
    btn_load = 1'b0;
    tick(LAT + 2);
    m_load(6'h27);
    check_all("held");

    // load ignored while presenting
    press_load(6'h09);
    press_load(6'h02);
    check_all("to_present");
    sw = 6'h3F;
    btn_load = 1'b1;
    ones = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (op_valid === 1'b1) ones++;
    end
    btn_load = 1'b0;
    chk("present_valid_50", 32'(ones), 32'(50));
    tick(LAT + 2);
    check_all("present_ignore");

    // clear together with a handshake in PRESENT
    btn_clear = 1'b1;
    tick(LAT - 1);
    chk("clr_rdy_valid", 32'(op_valid), 32'(1));
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    m_clear();
    check_all("clr_rdy");
    btn_clear = 1'b0;
    tick(LAT + 2);

    // plain clear after loading A
    press_load(6'h11);
    check_all("a_11");
    press_clear();
    check_all("clear");

    // asynchronous reset in LOAD_OP
    press_load(6'h1E);
    press_load(6'h33);
    check_all("to_load_op");
    #3 rst_n = 1'b0;
    #1;
    m_clear();
    check_all("async_reset");
    #2 rst_n = 1'b1;
    tick(2);
    press_load(6'h05);
    check_all("restart");

    // randomized mix of loads, clears and ready pulses
    for (int i = 0; i < 40; i++) begin
      int act;
      act = int'($urandom_range(0, 9));
      if (act < 6)      press_load(6'($urandom));
      else if (act < 8) ready_pulse();
      else              press_clear();
      check_all($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Input stage directly upstream of the 6-bit ALU operation units (XOR, etc.).
- Sequentially captures operand A, operand B and the opcode from one shared 6-bit switch bank, using a "load" push-button.
- Presents the captured word to the ALU/result stage with a valid/ready handshake.
- Holds the outputs stable so the operation units and the display see steady operands.

Parameters:
- DATA_W, 6, operand width (A, B, switch bank).
- OP_W, 2, opcode width; the opcode is taken from sw[OP_W-1:0].
- DB_CYCLES, 500000, number of consecutive stable cycles required by the debounce filter (used only with the macro defined).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  DATA_W  raw switch bank, asynchronous.
- btn_load  in  1  raw load button, asynchronous, active-high.
- btn_clear  in  1  raw clear button, asynchronous, active-high.
- A  out  DATA_W  captured operand A.
- B  out  DATA_W  captured operand B.
- op  out  OP_W  captured opcode.
- op_valid  out  1  operand set complete and offered downstream.
- op_ready  in  1  downstream accepts the operand set.
- state_o  out  2  current FSM state, for LEDs.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low (rst_n).
- Reset values: A=0, B=0, op=0, op_valid=0, state=LOAD_A (state_o=2'b00).
- Each button goes through a 2-flop synchronizer, then the conditioner, then a rising-edge detect. The result is a 1-cycle pulse: load_p or clr_p.
- sw is sampled in the same cycle load_p is high. sw is not synchronized; the user holds it static during the press.
- FSM encoding: LOAD_A=00, LOAD_B=01, LOAD_OP=10, PRESENT=11.
  - LOAD_A + load_p: A<=sw; go to LOAD_B.
  - LOAD_B + load_p: B<=sw; go to LOAD_OP.
  - LOAD_OP + load_p: op<=sw[OP_W-1:0]; go to PRESENT; op_valid=1 from the next cycle.
  - PRESENT: op_valid is held high. A, B and op are frozen. load_p is ignored.
  - PRESENT with op_valid && op_ready at a clock edge: transfer completes. Next state is LOAD_A; op_valid=0 the next cycle.
  - A, B and op keep their values after the transfer and are only overwritten by the next loads.
- op_valid is registered and is high only in PRESENT. It never depends combinationally on op_ready.
- clr_p in any state: A=B=op=0, op_valid=0, state=LOAD_A on the next cycle. clr_p has priority over load_p.
- clr_p and op_ready in the same PRESENT cycle: the handshake counts as completed (downstream may sample it), and the clear still applies.
- op_ready while not in PRESENT: ignored.
- Held button: exactly one pulse per press. No auto-repeat.
- Reset asserted mid-sequence returns immediately to reset values and discards partial loads.
- Latency from a raw button rising edge to register update: 2 (sync) + filter delay + 1 (edge) cycles.

Optional Feature:
- Macro: ALU_LOADER_DEBOUNCE_EN.
- Defined: the conditioner's output level changes only after its synchronized input has differed from the output for DB_CYCLES consecutive cycles. Any bounce restarts the count.
  - Filter delay = DB_CYCLES cycles.
  - Counter width = $clog2(DB_CYCLES+1).
- Undefined: no filter; the conditioner output equals the synchronized input. Filter delay = 0, and DB_CYCLES is unused.

Decomposition:
- Package alu_pkg:
  - DATA_W and OP_W defaults.
  - Loader state enum (LOAD_A/LOAD_B/LOAD_OP/PRESENT, 2-bit).
  - Opcode constants for the ALU operations (e.g. OP_XOR).
- Sub-module button_conditioner: synchronizer, optional debounce and rising-edge pulse. Instantiated twice, once for load and once for clear.

Test Plan:
- Macro defined, DB_CYCLES=4:
  - Reset, then press load three times with sw=6'h2A, 6'h15, 6'h03 -> A=2A, B=15, op=3, op_valid=1, state_o=11.
  - Hold op_ready=1 one cycle -> op_valid=0 next cycle, state_o=00, A/B/op unchanged.
- Bounce: btn_load toggles 1/0 every 2 cycles for 10 cycles, then stays high -> exactly one capture, occurring 2+4+1=7 cycles after the final rise.
- In PRESENT with op_ready=0: press load with sw=6'h3F -> no change, op_valid stays 1 for 50 cycles.
- After loading A=0x11, press clear (and separately assert clear together with op_ready in PRESENT) -> A=B=op=0, op_valid=0, state_o=00.
- rst_n pulsed low asynchronously mid-cycle while in LOAD_OP -> outputs reach reset values immediately. Sequence restarts at LOAD_A.
- Macro undefined: a single clean press -> capture 3 cycles after the raw edge. A button held 100 cycles -> only one capture.
